// File: rtl/soc_msp430_trace_encoder_if.sv
// Trace word stream: one 32-bit word per valid & ready handshake.
// master drives valid/data and holds them stable while ready is low.
interface soc_msp430_trace_encoder_if;
  logic        trace_valid;
  logic [31:0] trace_data;
  logic        trace_ready;

  modport master (output trace_valid, output trace_data, input trace_ready);
  modport slave  (input trace_valid, input trace_data, output trace_ready);
endinterface

// File: rtl/soc_msp430_trace_encoder.sv
// openMSP430 instruction trace: one {A,B} packet per decode, buffered and streamed as two words.
// Decode at edge N -> word A valid after N+1; a stalled sink fills the FIFO, then packets drop and are counted.

module fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // full/empty come from the registered count, so a same-cycle pop never frees room for a push
  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

module soc_msp430_trace_encoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic                 mclk,
  input  logic                 puc_rst_n,
  input  logic                 decode,
  input  logic [15:0]          ir,
  input  logic [15:0]          pc,
  input  logic                 irq_detect,
  input  logic [3:0]           irq_num,
  input  logic                 trace_en,
  input  logic                 clr_ovf,
  soc_msp430_trace_encoder_if.master trace,
  output logic [FIFO_AW:0]     trace_level,
  output logic                 overflow,
  output logic [7:0]           drop_count
);
  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;

  state_t      state;
  state_t      next_state;
  logic [8:0]  cyc;
  logic [13:0] seq;
  logic [63:0] pkt;
  logic [63:0] hold;
  logic [63:0] fifo_out;
  logic        capture;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        drop;

  assign capture = decode & trace_en;
  assign drop    = capture & fifo_full;
  assign pkt     = {2'b01, irq_detect, (irq_detect ? irq_num : 4'h0), cyc, pc,
                    2'b10, seq, ir};

  fifo #(.W(64), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk      (mclk),
    .rst_n    (puc_rst_n),
    .push     (capture),
    .push_dat (pkt),
    .pop      (pop),
    .pop_dat  (fifo_out),
    .count    (trace_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // cyc measures the length of the instruction that precedes each decode
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      cyc <= '0;
      seq <= '0;
    end else begin
      if (decode)              cyc <= 9'd1;
      else if (cyc != 9'h1FF)  cyc <= cyc + 9'd1;
      if (capture)             seq <= seq + 14'd1;
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= clr_ovf ? 8'd1 : ((drop_count == 8'hFF) ? 8'hFF : drop_count + 8'd1);
    end else if (clr_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= next_state;
      if (pop) hold <= fifo_out;
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = SEND_A;
        end
      end
      SEND_A: begin
        if (trace.trace_ready) next_state = SEND_B;
      end
      SEND_B: begin
        if (trace.trace_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = SEND_A;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    trace.trace_valid = 1'b0;
    trace.trace_data  = '0;
    case (state)
      SEND_A: begin
        trace.trace_valid = 1'b1;
        trace.trace_data  = hold[63:32];
      end
      SEND_B: begin
        trace.trace_valid = 1'b1;
        trace.trace_data  = hold[31:0];
      end
      default: begin
        trace.trace_valid = 1'b0;
        trace.trace_data  = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_soc_msp430_trace_encoder.sv
// Directed bench for the trace encoder: latency, irq packets, overflow, stall, clr_ovf, cycle saturation.
module tb_soc_msp430_trace_encoder;
  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b0;
  logic        decode = 1'b0;
  logic [15:0] ir = '0;
  logic [15:0] pc = '0;
  logic        irq_detect = 1'b0;
  logic [3:0]  irq_num = '0;
  logic        trace_en = 1'b1;
  logic        clr_ovf = 1'b0;
  logic [3:0]  trace_level;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] got_q[$];
  int          first_c;
  int          last_c;
  logic [31:0] exp_w;
  logic [31:0] got_w;

  soc_msp430_trace_encoder_if trace_if();

  soc_msp430_trace_encoder #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .mclk        (mclk),
    .puc_rst_n   (puc_rst_n),
    .decode      (decode),
    .ir          (ir),
    .pc          (pc),
    .irq_detect  (irq_detect),
    .irq_num     (irq_num),
    .trace_en    (trace_en),
    .clr_ovf     (clr_ovf),
    .trace       (trace_if),
    .trace_level (trace_level),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    puc_rst_n = 1'b0;
    decode = 1'b0; irq_detect = 1'b0; irq_num = '0; clr_ovf = 1'b0;
    trace_en = 1'b1; trace_if.trace_ready = 1'b1;
    @(negedge mclk);
    @(negedge mclk);
    puc_rst_n = 1'b1;
  endtask

  task automatic collect(input int cycles);
    got_q.delete();
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < cycles; c++) begin
      if (trace_if.trace_valid && trace_if.trace_ready) begin
        got_q.push_back(trace_if.trace_data);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      @(negedge mclk);
    end
  endtask

  initial begin
    trace_if.trace_ready = 1'b1;
    do_reset();
    chk("rst_valid", 32'(trace_if.trace_valid), 32'd0);
    chk("rst_data", trace_if.trace_data, 32'd0);
    chk("rst_level", 32'(trace_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);

    // single decode five cycles after release, then an irq decode three cycles later
    repeat (5) @(negedge mclk);
    decode = 1'b1; pc = 16'hF800; ir = 16'h4303;
    @(negedge mclk);
    decode = 1'b0;
    chk("lat_idle", 32'(trace_if.trace_valid), 32'd0);
    @(negedge mclk);
    chk("a0_valid", 32'(trace_if.trace_valid), 32'd1);
    chk("a0_data", trace_if.trace_data, 32'h4005F800);
    @(negedge mclk);
    chk("b0_valid", 32'(trace_if.trace_valid), 32'd1);
    chk("b0_data", trace_if.trace_data, 32'h80004303);
    decode = 1'b1; pc = 16'hFFFC; ir = 16'h1234; irq_detect = 1'b1; irq_num = 4'hE;
    @(negedge mclk);
    decode = 1'b0; irq_detect = 1'b0;
    chk("two_cyc_valid", 32'(trace_if.trace_valid), 32'd0);
    @(negedge mclk);
    chk("irq_a", trace_if.trace_data, 32'h7C03FFFC);
    @(negedge mclk);
    chk("irq_b", trace_if.trace_data, 32'h80011234);
    @(negedge mclk);
    chk("irq_done", 32'(trace_if.trace_valid), 32'd0);

    // stalled sink with ten back-to-back decodes
    do_reset();
    trace_if.trace_ready = 1'b0;
    repeat (2) @(negedge mclk);
    for (int i = 0; i < 10; i++) begin
      decode = 1'b1; pc = 16'h0100 + 16'(i); ir = 16'hA000 + 16'(i);
      @(negedge mclk);
    end
    decode = 1'b0;
    chk("ovf_level", 32'(trace_level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd1);
    chk("ovf_hold_a", trace_if.trace_data, 32'h40020100);
    trace_if.trace_ready = 1'b1;
    collect(40);
    chk("drain_cnt", 32'(got_q.size()), 32'd18);
    chk("drain_b2b", 32'(last_c - first_c), 32'd17);
    for (int i = 0; i < 9; i++) begin
      exp_w = (i == 0) ? 32'h40020100 : (32'h40010100 + 32'(i));
      got_w = (2*i < got_q.size()) ? got_q[2*i] : 32'hDEADBEEF;
      chk($sformatf("drain_a%0d", i), got_w, exp_w);
      exp_w = 32'h8000A000 + (32'(i) << 16) + 32'(i);
      got_w = (2*i+1 < got_q.size()) ? got_q[2*i+1] : 32'hDEADBEEF;
      chk($sformatf("drain_b%0d", i), got_w, exp_w);
    end
    chk("drain_level", 32'(trace_level), 32'd0);

    // ready stalled for four cycles while word B is presented
    do_reset();
    repeat (3) @(negedge mclk);
    decode = 1'b1; pc = 16'h1000; ir = 16'h2000;
    @(negedge mclk);
    decode = 1'b0;
    @(negedge mclk);
    chk("stall_a", trace_if.trace_data, 32'h40031000);
    @(negedge mclk);
    trace_if.trace_ready = 1'b0;
    decode = 1'b1; pc = 16'h1100; ir = 16'h2100;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_hold%0d", i), trace_if.trace_data, 32'h80002000);
      chk($sformatf("stall_vld%0d", i), 32'(trace_if.trace_valid), 32'd1);
      @(negedge mclk);
      decode = 1'b0;
    end
    trace_if.trace_ready = 1'b1;
    collect(10);
    chk("stall_cnt", 32'(got_q.size()), 32'd3);
    got_w = (got_q.size() > 0) ? got_q[0] : 32'hDEADBEEF;
    chk("stall_w0", got_w, 32'h80002000);
    got_w = (got_q.size() > 1) ? got_q[1] : 32'hDEADBEEF;
    chk("stall_w1", got_w, 32'h40031100);
    got_w = (got_q.size() > 2) ? got_q[2] : 32'hDEADBEEF;
    chk("stall_w2", got_w, 32'h80012100);

    // clr_ovf coinciding with a drop, then a lone clr_ovf
    do_reset();
    trace_if.trace_ready = 1'b0;
    @(negedge mclk);
    for (int i = 0; i < 12; i++) begin
      if (i == 11) begin
        chk("pre_clr_drops", 32'(drop_count), 32'd2);
        clr_ovf = 1'b1;
      end
      decode = 1'b1; pc = 16'(i); ir = 16'(i);
      @(negedge mclk);
    end
    decode = 1'b0; clr_ovf = 1'b0;
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_drop_cnt", 32'(drop_count), 32'd1);
    clr_ovf = 1'b1;
    @(negedge mclk);
    clr_ovf = 1'b0;
    chk("clr_lone_ovf", 32'(overflow), 32'd0);
    chk("clr_lone_cnt", 32'(drop_count), 32'd0);
    trace_if.trace_ready = 1'b1;
    collect(40);
    chk("clr_drain_cnt", 32'(got_q.size()), 32'd18);

    // disabled decode, long idle gap, then an enabled decode
    do_reset();
    trace_en = 1'b0;
    decode = 1'b1; pc = 16'hBEEF; ir = 16'hBEEF;
    @(negedge mclk);
    decode = 1'b0;
    @(negedge mclk);
    chk("dis_level", 32'(trace_level), 32'd0);
    chk("dis_valid", 32'(trace_if.trace_valid), 32'd0);
    repeat (600) @(negedge mclk);
    trace_en = 1'b1;
    decode = 1'b1; pc = 16'hC000; ir = 16'h5555;
    @(negedge mclk);
    decode = 1'b0;
    @(negedge mclk);
    chk("sat_a", trace_if.trace_data, 32'h41FFC000);
    @(negedge mclk);
    chk("sat_b_seq0", trace_if.trace_data, 32'h80005555);

    // asynchronous reset drops an in-flight word without a clock edge
    decode = 1'b1; pc = 16'h0042; ir = 16'h0042;
    @(negedge mclk);
    decode = 1'b0;
    @(negedge mclk);
    chk("arst_pre_valid", 32'(trace_if.trace_valid), 32'd1);
    #1 puc_rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(trace_if.trace_valid), 32'd0);
    chk("arst_data", trace_if.trace_data, 32'd0);
    chk("arst_level", 32'(trace_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
